// File: rtl/hdmi_timing_pkg.sv
// Shared types and constant helpers for the HDMI video timing generator.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam bit SYNC_ACTIVE_HIGH = 1'b1;
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_last;
    } axis_timing_t;

    // Sync end is kept inclusive so it always fits in the counter width,
    // even when the back porch is zero.
    function automatic axis_timing_t calc_axis_timing(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        axis_timing_t t;
        t.total      = active + fp + sync + bp;
        t.sync_start = active + fp;
        t.sync_last  = active + fp + sync - 1;
        return t;
    endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters with region decode and frame strobes.
module hdmi_timing_counter
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    output logic active,
    output logic hsync_region,
    output logic vsync_region,
    output logic first_pix,
    output logic last_pix
);

    localparam axis_timing_t HT = calc_axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam axis_timing_t VT = calc_axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned  HW = $clog2(HT.total);
    localparam int unsigned  VW = $clog2(VT.total);

    localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(HT.sync_start);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(HT.sync_last);
    localparam logic [HW-1:0] H_LAST       = HW'(HT.total - 1);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(VT.sync_start);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(VT.sync_last);
    localparam logic [VW-1:0] V_LAST       = VW'(VT.total - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Disabled counters collapse to the origin so enabling always starts a fresh frame.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!count_en) begin
            h_d = '0;
            v_d = '0;
        end else if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active       = (h_q <= H_ACT_LAST) && (v_q <= V_ACT_LAST);
    assign hsync_region = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
    assign vsync_region = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
    assign first_pix    = (h_q == '0) && (v_q == '0);
    assign last_pix     = h_wrap && v_wrap;

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI video timing generator: locks a pixel stream to the raster using its
// start-of-frame marker and drives registered DE/HSYNC/VSYNC/DATA pins.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned H_ACTIVE    = 1920,
    parameter int unsigned H_FP        = 88,
    parameter int unsigned H_SYNC      = 44,
    parameter int unsigned H_BP        = 148,
    parameter int unsigned V_ACTIVE    = 1080,
    parameter int unsigned V_FP        = 4,
    parameter int unsigned V_SYNC      = 5,
    parameter int unsigned V_BP        = 36,
    parameter bit          HSYNC_POL   = SYNC_ACTIVE_HIGH,
    parameter bit          VSYNC_POL   = SYNC_ACTIVE_HIGH
) (
    input  logic                   ACLK,
    input  logic                   nRST,
    input  logic                   EN,
    input  logic                   S_PIXEL_VALID,
    input  logic [PIXEL_WIDTH-1:0] S_PIXEL_DATA,
    input  logic                   S_PIXEL_SOF,
    output logic                   S_PIXEL_READY,
    output logic                   FRAME_START,
    output logic                   UNDERFLOW,
    output logic                   HDMI_DE,
    output logic                   HDMI_HSYNC,
    output logic                   HDMI_VSYNC,
    output logic [PIXEL_WIDTH-1:0] HDMI_DATA
);

    state_t state_q, state_d;

    logic count_en;
    logic active;
    logic hsync_region;
    logic vsync_region;
    logic first_pix;
    logic last_pix;
    logic pix_fault;

    logic                   de_q, de_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d;
    logic                   underflow_q, underflow_d;
    logic [PIXEL_WIDTH-1:0] data_q, data_d;

    assign count_en = EN && (state_q != ST_IDLE);

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .clk          (ACLK),
        .rst_n        (nRST),
        .count_en     (count_en),
        .active       (active),
        .hsync_region (hsync_region),
        .vsync_region (vsync_region),
        .first_pix    (first_pix),
        .last_pix     (last_pix)
    );

    // While running, an active slot needs a pixel whose SOF flag matches the frame origin.
    assign pix_fault = active && (!S_PIXEL_VALID || (S_PIXEL_SOF != first_pix));

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_WAIT_SOF;
                ST_WAIT_SOF: if (last_pix && S_PIXEL_VALID && S_PIXEL_SOF) state_d = ST_RUN;
                ST_RUN:      if (pix_fault) state_d = ST_WAIT_SOF;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        S_PIXEL_READY = 1'b0;
        de_d          = 1'b0;
        hsync_d       = !HSYNC_POL;
        vsync_d       = !VSYNC_POL;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        data_d        = '0;
        if (count_en) begin
            de_d          = active;
            hsync_d       = hsync_region ? HSYNC_POL : !HSYNC_POL;
            vsync_d       = vsync_region ? VSYNC_POL : !VSYNC_POL;
            frame_start_d = first_pix;
            case (state_q)
                // Flush stale pixels but park an SOF pixel until the frame boundary.
                ST_WAIT_SOF: S_PIXEL_READY = S_PIXEL_VALID && !S_PIXEL_SOF;
                ST_RUN: begin
                    if (pix_fault) begin
                        underflow_d = 1'b1;
                    end else if (active) begin
                        S_PIXEL_READY = 1'b1;
                        data_d        = S_PIXEL_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            de_q          <= 1'b0;
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            data_q        <= '0;
        end else begin
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            data_q        <= data_d;
        end
    end

    assign HDMI_DE     = de_q;
    assign HDMI_HSYNC  = hsync_q;
    assign HDMI_VSYNC  = vsync_q;
    assign FRAME_START = frame_start_q;
    assign UNDERFLOW   = underflow_q;
    assign HDMI_DATA   = data_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing using an 8x6 raster (4x3 active).
module tb_hdmi_video_timing;

    localparam int PW    = 24;
    localparam int HTOT  = 8;
    localparam int FRAME = 48;

    logic          ACLK = 1'b0;
    logic          nRST = 1'b0;
    logic          EN = 1'b0;
    logic          S_PIXEL_VALID = 1'b0;
    logic [PW-1:0] S_PIXEL_DATA = '0;
    logic          S_PIXEL_SOF = 1'b0;
    logic          S_PIXEL_READY;
    logic          FRAME_START;
    logic          UNDERFLOW;
    logic          HDMI_DE;
    logic          HDMI_HSYNC;
    logic          HDMI_VSYNC;
    logic [PW-1:0] HDMI_DATA;

    always #5 ACLK = ~ACLK;

    hdmi_video_timing #(
        .PIXEL_WIDTH (PW),
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut (
        .ACLK          (ACLK),
        .nRST          (nRST),
        .EN            (EN),
        .S_PIXEL_VALID (S_PIXEL_VALID),
        .S_PIXEL_DATA  (S_PIXEL_DATA),
        .S_PIXEL_SOF   (S_PIXEL_SOF),
        .S_PIXEL_READY (S_PIXEL_READY),
        .FRAME_START   (FRAME_START),
        .UNDERFLOW     (UNDERFLOW),
        .HDMI_DE       (HDMI_DE),
        .HDMI_HSYNC    (HDMI_HSYNC),
        .HDMI_VSYNC    (HDMI_VSYNC),
        .HDMI_DATA     (HDMI_DATA)
    );

    typedef struct packed {
        logic          sof;
        logic [PW-1:0] data;
    } pix_t;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          uf;
        logic [PW-1:0] data;
    } exp_t;

    pix_t src_q[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int m_st  = 0;   // 0 idle, 1 waiting for SOF, 2 locked
    int m_pos = 0;   // raster position inside the frame
    bit valid_gate = 1'b1;
    int cyc = 0;

    int obs_de, obs_px, obs_hs, obs_vs, obs_uf, obs_fs, obs_hsk, obs_fs_gap, fs_cyc_last;
    logic [PW-1:0] obs_fs_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_obs();
        obs_de = 0; obs_px = 0; obs_hs = 0; obs_vs = 0; obs_uf = 0;
        obs_fs = 0; obs_hsk = 0; obs_fs_gap = 0; fs_cyc_last = -1; obs_fs_data = '0;
    endtask

    task automatic push_frames(input int n, input logic [PW-1:0] sof_val);
        pix_t p;
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 12; i++) begin
                p.sof  = (i == 0);
                p.data = (i == 0) ? sof_val : (PW'($urandom) | 24'h000001);
                src_q.push_back(p);
            end
        end
    endtask

    // One clock: drive, predict, compare READY now and registered outputs after the edge.
    task automatic step();
        exp_t e;
        exp_t got_e;
        logic rdy, hsk, counting, act, first, last;
        int   h, v, nst;
        pix_t head;
        if (valid_gate && src_q.size() > 0) begin
            S_PIXEL_VALID = 1'b1;
            S_PIXEL_DATA  = src_q[0].data;
            S_PIXEL_SOF   = src_q[0].sof;
        end else begin
            S_PIXEL_VALID = 1'b0;
            S_PIXEL_DATA  = '0;
            S_PIXEL_SOF   = 1'b0;
        end
        #1;
        counting = EN && (m_st != 0);
        h = m_pos % HTOT;
        v = m_pos / HTOT;
        act   = (h < 4) && (v < 3);
        first = (m_pos == 0);
        last  = (m_pos == FRAME - 1);
        e = '0;
        e.de = counting && act;
        e.hs = counting && (h >= 5) && (h < 7);
        e.vs = counting && (v == 4);
        e.fs = counting && first;
        rdy = 1'b0;
        nst = m_st;
        if (!EN) nst = 0;
        else if (m_st == 0) nst = 1;
        else if (m_st == 1) begin
            rdy = S_PIXEL_VALID && !S_PIXEL_SOF;
            if (last && S_PIXEL_VALID && S_PIXEL_SOF) nst = 2;
        end else if (act) begin
            if (!S_PIXEL_VALID || (S_PIXEL_SOF != first)) begin
                e.uf = 1'b1;
                nst  = 1;
            end else begin
                rdy    = 1'b1;
                e.data = S_PIXEL_DATA;
            end
        end
        sb_q.push_back(e);
        check_val("ready", 32'(S_PIXEL_READY), 32'(rdy));
        hsk = S_PIXEL_VALID && S_PIXEL_READY;
        @(posedge ACLK);
        #1;
        cyc++;
        if (hsk) begin
            head = src_q.pop_front();
            obs_hsk++;
            $display("px cyc=%0d data=%06h sof=%0b", cyc, head.data, head.sof);
        end
        m_pos = counting ? (m_pos + 1) % FRAME : 0;
        m_st  = nst;
        got_e = sb_q.pop_front();
        check_val("de",    32'(HDMI_DE),     32'(got_e.de));
        check_val("hsync", 32'(HDMI_HSYNC),  32'(got_e.hs));
        check_val("vsync", 32'(HDMI_VSYNC),  32'(got_e.vs));
        check_val("fs",    32'(FRAME_START), 32'(got_e.fs));
        check_val("uf",    32'(UNDERFLOW),   32'(got_e.uf));
        check_val("data",  32'(HDMI_DATA),   32'(got_e.data));
        if (HDMI_DE) obs_de++;
        if (HDMI_DE && HDMI_DATA != '0) obs_px++;
        if (HDMI_HSYNC) obs_hs++;
        if (HDMI_VSYNC) obs_vs++;
        if (UNDERFLOW) obs_uf++;
        if (FRAME_START) begin
            if (fs_cyc_last >= 0) obs_fs_gap = cyc - fs_cyc_last;
            fs_cyc_last = cyc;
            obs_fs_data = HDMI_DATA;
            obs_fs++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int pos, input int st);
        int k;
        k = 0;
        while (!(m_pos == pos && m_st == st) && k < 200) begin
            step();
            k++;
        end
        check_val("wait_pos", 32'(m_pos * 4 + m_st), 32'(pos * 4 + st));
    endtask

    initial begin
        pix_t p;
        clr_obs();
        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_de",    32'(HDMI_DE),       32'd0);
        check_val("rst_data",  32'(HDMI_DATA),     32'd0);
        check_val("rst_hsync", 32'(HDMI_HSYNC),    32'd0);
        check_val("rst_vsync", 32'(HDMI_VSYNC),    32'd0);
        check_val("rst_fs",    32'(FRAME_START),   32'd0);
        check_val("rst_uf",    32'(UNDERFLOW),     32'd0);
        check_val("rst_ready", 32'(S_PIXEL_READY), 32'd0);
        nRST = 1'b1;

        // Sync timing with a continuous aligned stream
        push_frames(8, 24'hA00001);
        EN = 1'b1;
        run(1 + FRAME + FRAME);
        clr_obs();
        run(2 * FRAME);
        check_val("t1_de_cnt", 32'(obs_de),     32'd24);
        check_val("t1_hs_cnt", 32'(obs_hs),     32'd24);
        check_val("t1_vs_cnt", 32'(obs_vs),     32'd16);
        check_val("t1_fs_cnt", 32'(obs_fs),     32'd2);
        check_val("t1_fs_gap", 32'(obs_fs_gap), 32'd48);
        check_val("t1_px_cnt", 32'(obs_px),     32'd24);
        check_val("t1_uf_cnt", 32'(obs_uf),     32'd0);

        // Lock-in after three stale pixels
        EN = 1'b0;
        run(2);
        src_q.delete();
        for (int i = 0; i < 3; i++) begin
            p.sof  = 1'b0;
            p.data = 24'h0A0B01 + 24'(i);
            src_q.push_back(p);
        end
        push_frames(20, 24'h112233);
        clr_obs();
        EN = 1'b1;
        run(1 + FRAME);
        check_val("t2_flushed", 32'(obs_hsk), 32'd3);
        run(1);
        check_val("t2_fs_cnt",  32'(obs_fs),      32'd2);
        check_val("t2_first",   32'(obs_fs_data), 32'h112233);
        run(FRAME);
        check_val("t2_uf_cnt",  32'(obs_uf),      32'd0);

        // Underflow at h=2, v=1
        wait_pos(10, 2);
        clr_obs();
        valid_gate = 1'b0;
        step();
        valid_gate = 1'b1;
        check_val("t3_uf_now",  32'(obs_uf), 32'd1);
        check_val("t3_de_now",  32'(obs_de), 32'd1);
        check_val("t3_px_zero", 32'(obs_px), 32'd0);
        run(FRAME + 10);
        check_val("t3_uf_once", 32'(obs_uf), 32'd1);
        clr_obs();
        run(FRAME);
        check_val("t3_relock",  32'(obs_px), 32'd12);

        // Misaligned SOF at h=1, v=0
        wait_pos(1, 2);
        clr_obs();
        p.sof  = 1'b1;
        p.data = 24'hC0FFEE;
        src_q.push_front(p);
        step();
        check_val("t4_uf",      32'(obs_uf),  32'd1);
        check_val("t4_no_take", 32'(obs_hsk), 32'd0);
        wait_pos(0, 2);
        step();
        check_val("t4_sof_out", 32'(obs_fs_data), 32'hC0FFEE);
        check_val("t4_uf_once", 32'(obs_uf),      32'd1);

        // EN dropped at h=3, v=1
        wait_pos(11, 2);
        EN = 1'b0;
        step();
        check_val("t5_de",    32'(HDMI_DE),    32'd0);
        check_val("t5_hsync", 32'(HDMI_HSYNC), 32'd0);
        check_val("t5_vsync", 32'(HDMI_VSYNC), 32'd0);
        step();
        EN = 1'b1;
        clr_obs();
        run(1);
        check_val("t5_idle_fs",  32'(obs_fs), 32'd0);
        run(1);
        check_val("t5_restart",  32'(obs_fs), 32'd1);

        // Asynchronous reset in the middle of an active line
        wait_pos(1, 2);
        step();
        check_val("t6_pre_de", 32'(HDMI_DE), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_val("t6_de",    32'(HDMI_DE),       32'd0);
        check_val("t6_data",  32'(HDMI_DATA),     32'd0);
        check_val("t6_hsync", 32'(HDMI_HSYNC),    32'd0);
        check_val("t6_vsync", 32'(HDMI_VSYNC),    32'd0);
        check_val("t6_fs",    32'(FRAME_START),   32'd0);
        check_val("t6_uf",    32'(UNDERFLOW),     32'd0);
        check_val("t6_ready", 32'(S_PIXEL_READY), 32'd0);
        m_st  = 0;
        m_pos = 0;
        @(posedge ACLK);
        #1;
        nRST = 1'b1;
        run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
